// File: rtl/fighter_action_ctrl.sv
// Per-player fighter action/position controller: key levels in, one-hot action
// plus world x, ground y and background scroll out, all advanced once per frame.
module fighter_action_ctrl #(
    parameter int START_X      = 200,
    parameter int GROUND_Y     = 224,
    parameter int STEP         = 4,
    parameter int WORLD_W      = 1424,
    parameter int SCREEN_W     = 640,
    parameter int MAX_SPRITE_W = 192,
    parameter int SCR_L        = 64,
    parameter int SCR_R        = 320,
    parameter int PUNCH_FRAMES = 28,
    parameter int KICK_FRAMES  = 35
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_tick,
    input  logic        key_left,
    input  logic        key_right,
    input  logic        key_down,
    input  logic        key_punch,
    input  logic        key_kick,
    output logic        forward,
    output logic        back,
    output logic        punch,
    output logic        squat,
    output logic        kick,
    output logic [12:0] charX,
    output logic [12:0] charY,
    output logic [12:0] backX,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        ST_STAND = 3'd0,
        ST_FWD   = 3'd1,
        ST_BACK  = 3'd2,
        ST_SQUAT = 3'd3,
        ST_PUNCH = 3'd4,
        ST_KICK  = 3'd5
    } state_t;

    localparam int CNT_W = 6;
    localparam logic [13:0] X_MAX = 14'(WORLD_W - MAX_SPRITE_W);
    localparam logic [13:0] B_MAX = 14'(WORLD_W - SCREEN_W);
    localparam logic [13:0] STEP_W = 14'(STEP);
    localparam logic signed [14:0] LIM_L = 15'(SCR_L);
    localparam logic signed [14:0] LIM_R = 15'(SCR_R);

    state_t             state, next_state;
    logic [CNT_W-1:0]   cnt, next_cnt;
    logic               punch_prev, kick_prev;
    logic               punch_edge, kick_edge;
    logic [13:0]        x_ext, sum_fwd, nx, sr, nb;
    logic signed [14:0] diff, sl;
    logic [12:0]        next_char_x, next_back_x;

    assign punch_edge = key_punch & ~punch_prev;
    assign kick_edge  = key_kick & ~kick_prev;

    // State and datapath registers; every update is gated by the frame tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_STAND;
            cnt        <= '0;
            punch_prev <= 1'b0;
            kick_prev  <= 1'b0;
            charX      <= 13'(START_X);
            backX      <= '0;
        end else if (frame_tick) begin
            state      <= next_state;
            cnt        <= next_cnt;
            punch_prev <= key_punch;
            kick_prev  <= key_kick;
            charX      <= next_char_x;
            backX      <= next_back_x;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            ST_PUNCH: begin
                if (cnt == CNT_W'(PUNCH_FRAMES - 1)) begin
                    next_state = ST_STAND;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            ST_KICK: begin
                if (cnt == CNT_W'(KICK_FRAMES - 1)) begin
                    next_state = ST_STAND;
                    next_cnt   = '0;
                end else begin
                    next_cnt = cnt + 1'b1;
                end
            end
            default: begin
                // Attack edges outrank every held direction, including down.
                if (kick_edge) begin
                    next_state = ST_KICK;
                    next_cnt   = '0;
                end else if (punch_edge) begin
                    next_state = ST_PUNCH;
                    next_cnt   = '0;
                end else if (key_down) begin
                    next_state = ST_SQUAT;
                end else if (key_right && !key_left) begin
                    next_state = ST_FWD;
                end else if (key_left && !key_right) begin
                    next_state = ST_BACK;
                end else begin
                    next_state = ST_STAND;
                end
            end
        endcase
    end

    // Walk integration and scroll follow, both keyed off the next state.
    always_comb begin
        x_ext   = {1'b0, charX};
        sum_fwd = x_ext + STEP_W;
        nx      = x_ext;
        if (next_state == ST_FWD) begin
            nx = (sum_fwd > X_MAX) ? X_MAX : sum_fwd;
        end else if (next_state == ST_BACK) begin
            nx = (x_ext < STEP_W) ? 14'd0 : x_ext - STEP_W;
        end
        diff = $signed({1'b0, nx}) - $signed({2'b00, backX});
        sr   = nx - 14'(SCR_R);
        sl   = $signed({1'b0, nx}) - LIM_L;
        nb   = {1'b0, backX};
        if (next_state == ST_FWD || next_state == ST_BACK) begin
            if (diff > LIM_R) begin
                nb = (sr > B_MAX) ? B_MAX : sr;
            end else if (diff < LIM_L) begin
                nb = (sl < 0) ? 14'd0 : sl[13:0];
            end
        end
        next_char_x = nx[12:0];
        next_back_x = nb[12:0];
    end

    always_comb begin
        forward   = (state == ST_FWD);
        back      = (state == ST_BACK);
        squat     = (state == ST_SQUAT);
        punch     = (state == ST_PUNCH);
        kick      = (state == ST_KICK);
        busy      = (state == ST_PUNCH) || (state == ST_KICK);
        charY     = 13'(GROUND_Y);
        state_dbg = state;
    end

endmodule
